// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
//   state_e  : arbiter FSM states
//   owner_e  : which requester owns the in-flight transaction
//   STREAK_W : width of the data-grant fairness counter
package mem_arb_pkg;

  localparam int STREAK_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  // Saturating increment of the fairness streak.
  function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] s,
                                                     input logic [STREAK_W-1:0] lim);
    return (s >= lim) ? lim : s + STREAK_W'(1);
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner pick between fetch and data requests.
//   if_req, d_req : pending requests
//   at_limit      : data streak has reached the fairness limit
//   gnt_vld       : some requester wins this cycle
//   gnt_owner     : OWN_D or OWN_IF
module mem_arb_select
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  logic at_limit,
  output logic gnt_vld,
  output logic gnt_owner
);

  always_comb begin
    gnt_vld   = if_req | d_req;
    gnt_owner = OWN_IF;
    // Data has priority unless fetch has been starved for a full streak.
    if (d_req && !(if_req && at_limit)) gnt_owner = OWN_D;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and
// data access. One transaction in flight at a time; the owner receives a
// one-cycle done pulse with its read data held in a registered output.
//   clk, reset               : clock, synchronous active-high reset
//   if_req/if_addr           : fetch request (held until if_done)
//   if_done/if_rdata         : fetch completion pulse and data
//   d_req/d_we/d_addr/...    : data request (held until d_done)
//   d_done/d_rdata           : data completion pulse and load data
//   m_req/m_we/m_addr/...    : memory request, fields latched at grant
//   m_gnt/m_rvalid/m_rdata   : memory accept and response
//   busy                     : FSM not idle
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int FAIRNESS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_done,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_gnt,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [STREAK_W-1:0] FAIR_LIM = STREAK_W'(FAIRNESS);

  state_e              state_q,    state_d;
  logic                owner_q,    owner_d;
  logic [STREAK_W-1:0] streak_q,   streak_d;
  logic                m_req_q,    m_req_d;
  logic                m_we_q,     m_we_d;
  logic [ADDR_W-1:0]   m_addr_q,   m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q,  m_wdata_d;
  logic [STRB_W-1:0]   m_wstrb_q,  m_wstrb_d;
  logic                if_done_q,  if_done_d;
  logic                d_done_q,   d_done_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q,  d_rdata_d;
  logic                busy_q,     busy_d;

  logic gnt_vld, gnt_owner;

  mem_arb_select u_sel (
    .if_req    (if_req),
    .d_req     (d_req),
    .at_limit  (streak_q == FAIR_LIM),
    .gnt_vld   (gnt_vld),
    .gnt_owner (gnt_owner)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    streak_d   = streak_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_wstrb_d  = m_wstrb_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_done_d  = 1'b0;
    d_done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // No pending fetch means no starvation history to keep.
        if (!if_req) streak_d = '0;
        if (gnt_vld) begin
          owner_d = gnt_owner;
          m_req_d = 1'b1;
          state_d = ST_ISSUE;
          if (gnt_owner == OWN_D) begin
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_wstrb_d = d_wstrb;
            if (if_req) streak_d = streak_inc(streak_q, FAIR_LIM);
          end else begin
            m_we_d    = 1'b0;
            m_addr_d  = if_addr;
            m_wdata_d = '0;
            m_wstrb_d = '0;
            streak_d  = '0;
          end
        end
      end
      ST_ISSUE: begin
        if (m_gnt) begin
          // Address fields stay latched; only the request strobe drops.
          m_req_d = 1'b0;
          state_d = ST_WAIT;
          if (m_rvalid) begin
            state_d = ST_DONE;
            if (owner_q == OWN_D) d_rdata_d  = m_rdata;
            else                  if_rdata_d = m_rdata;
            d_done_d  = (owner_q == OWN_D);
            if_done_d = (owner_q == OWN_IF);
          end
        end
      end
      ST_WAIT: begin
        if (m_rvalid) begin
          state_d = ST_DONE;
          if (owner_q == OWN_D) d_rdata_d  = m_rdata;
          else                  if_rdata_d = m_rdata;
          d_done_d  = (owner_q == OWN_D);
          if_done_d = (owner_q == OWN_IF);
        end
      end
      ST_DONE: begin
        // Done pulse cycle: no arbitration, requesters may update req.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IF;
      streak_q   <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_wstrb_q  <= '0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      streak_q   <= streak_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_wstrb_q  <= m_wstrb_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_wstrb  = m_wstrb_q;
  assign if_done  = if_done_q;
  assign d_done   = d_done_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios followed by random
// fetch/data traffic against a behavioural memory and arbitration model.
module tb_mem_arbiter;

  localparam int F = 4;

  logic        clk, reset;
  logic        if_req, if_done, d_req, d_we, d_done;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb, m_wstrb;
  logic        m_req, m_we, m_gnt, m_rvalid, busy;
  logic [31:0] m_addr, m_wdata, m_rdata;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIRNESS(F)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_done(d_done), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural memory: unwritten words return an address-derived pattern.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    v = mem_rd(a);
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    mem[a] = v;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called in the first ISSUE cycle: gnt after gd low cycles, rvalid rd
  // cycles after gnt (0 = same cycle). Returns in the DONE cycle.
  task automatic serve(input int gd, input int rd);
    logic [31:0] a0, resp;
    a0 = m_addr;
    for (int i = 0; i < gd; i++) begin
      tick;
      chk("gnt_wait_hold", 64'({m_req, m_addr}), 64'({1'b1, a0}));
    end
    resp = m_we ? (32'hBAD0_0000 ^ $urandom) : mem_rd(m_addr);
    if (m_we) mem_wr(m_addr, m_wdata, m_wstrb);
    m_gnt = 1'b1;
    if (rd == 0) begin m_rvalid = 1'b1; m_rdata = resp; end
    tick;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = $urandom;
    if (rd > 0) begin
      repeat (rd - 1) tick;
      m_rvalid = 1'b1; m_rdata = resp;
      tick;
      m_rvalid = 1'b0;
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  typedef struct {
    logic        own_d;
    logic        st;
    logic [31:0] rd;
  } exp_t;
  exp_t sb[$];

  int          streak_m;
  logic        mreq_p, p_if, p_d, p_dwe, wd;
  logic [31:0] p_iaddr, p_daddr, p_dwd, ea, h_addr, h_wd;
  logic [3:0]  p_dws, h_ws;
  logic        h_we;
  exp_t        e;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete(); streak_m = 0; mreq_p = 0; p_if = 0; p_d = 0;
      end else begin
        if (m_req && !mreq_p) begin
          // Arbitration decided in the previous (IDLE) cycle.
          wd = p_d && !(p_if && streak_m == F);
          if (wd) begin
            streak_m = !p_if ? 0 : (streak_m < F ? streak_m + 1 : F);
            ea = p_daddr;
            chk("issue_we_strb", 64'({m_we, m_wstrb}), 64'({p_dwe, p_dws}));
            if (p_dwe) chk("issue_wdata", 64'(m_wdata), 64'(p_dwd));
          end else begin
            streak_m = 0;
            ea = p_iaddr;
            chk("issue_we_strb", 64'({m_we, m_wstrb}), 64'h0);
          end
          chk("issue_addr", 64'(m_addr), 64'(ea));
          e.own_d = wd; e.st = wd && p_dwe; e.rd = mem_rd(ea);
          sb.push_back(e);
          h_we = m_we; h_ws = m_wstrb; h_addr = m_addr; h_wd = m_wdata;
        end else if (m_req) begin
          chk("m_req_hold", 64'({m_we, m_wstrb, m_addr}), 64'({h_we, h_ws, h_addr}));
          chk("m_wdata_hold", 64'(m_wdata), 64'(h_wd));
        end
        if (if_done || d_done) begin
          if (sb.size() == 0) begin
            chk("spurious_done", 64'({if_done, d_done}), 64'h0);
          end else begin
            e = sb.pop_front();
            chk("done_owner", 64'({if_done, d_done}), e.own_d ? 64'h1 : 64'h2);
            if (!e.own_d)   chk("if_rdata", 64'(if_rdata), 64'(e.rd));
            else if (!e.st) chk("d_rdata", 64'(d_rdata), 64'(e.rd));
          end
        end
        p_if = if_req; p_iaddr = if_addr;
        p_d = d_req; p_dwe = d_we; p_daddr = d_addr; p_dwd = d_wdata; p_dws = d_wstrb;
        mreq_p = m_req;
      end
    end
  end

  // ---------------- random traffic ----------------
  logic fdn, ddn;

  task automatic rand_fetch(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) tick;
      if_req = 1'b1; if_addr = 32'($urandom_range(0, 15)) << 2;
      t = 0;
      do begin tick; t++; end while (!if_done && t < 100);
      chk("if_done_timeout", 64'(if_done), 64'h1);
      if_req = 1'b0;
    end
    fdn = 1'b1;
  endtask

  task automatic rand_data(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) tick;
      d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
      d_addr = 32'($urandom_range(0, 15)) << 2;
      d_wdata = $urandom; d_wstrb = 4'($urandom_range(1, 15));
      t = 0;
      do begin tick; t++; end while (!d_done && t < 100);
      chk("d_done_timeout", 64'(d_done), 64'h1);
      d_req = 1'b0;
    end
    ddn = 1'b1;
  endtask

  task automatic mem_loop;
    while (!(fdn && ddn)) begin
      tick;
      if (m_req) serve($urandom_range(0, 3), $urandom_range(0, 2));
    end
  endtask

  task automatic chk_idle_zero(input string nm);
    chk({nm, "_ctl"}, 64'({busy, m_req, m_we, if_done, d_done, m_wstrb}), 64'h0);
    chk({nm, "_addr"}, 64'(m_addr), 64'h0);
    chk({nm, "_wdata"}, 64'(m_wdata), 64'h0);
    chk({nm, "_rdata"}, 64'({if_rdata, d_rdata}), 64'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int t;
    reset = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
    d_wdata = 0; d_wstrb = 0; m_gnt = 0; m_rvalid = 0; m_rdata = 0;
    fdn = 0; ddn = 0;
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h300] = 32'hA5A5A5A5;
    repeat (3) tick;
    chk_idle_zero("reset");
    reset = 1'b0;
    tick;

    // Single fetch, gnt in ISSUE, rvalid one cycle later.
    if_req = 1; if_addr = 32'h100;                               // cycle 0
    tick;                                                        // cycle 1
    chk("fetch_issue", 64'({m_req, m_we, m_wstrb, m_addr}), 64'({1'b1, 1'b0, 4'h0, 32'h100}));
    m_gnt = 1;
    tick;                                                        // cycle 2
    m_gnt = 0; m_rvalid = 1; m_rdata = 32'hDEADBEEF;
    chk("fetch_early_done", 64'(if_done), 64'h0);
    tick;                                                        // cycle 3
    m_rvalid = 0;
    chk("fetch_done", 64'({if_done, d_done, if_rdata}), 64'({1'b1, 1'b0, 32'hDEADBEEF}));
    if_req = 0;
    tick;
    chk("fetch_pulse_end", 64'({if_done, busy}), 64'h0);

    // Simultaneous requests: store first, then fetch.
    if_req = 1; if_addr = 32'h104;
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h12345678; d_wstrb = 4'hF;
    tick;
    chk("simul_store_first", 64'({m_we, m_wstrb, m_addr}), 64'({1'b1, 4'hF, 32'h200}));
    serve(0, 1);
    chk("simul_store_done", 64'({if_done, d_done}), 64'h1);
    d_req = 0;
    tick; tick;
    chk("simul_fetch_next", 64'({m_req, m_we, m_addr}), 64'({1'b1, 1'b0, 32'h104}));
    serve(0, 1);
    chk("simul_fetch_done", 64'({if_done, d_done, if_rdata}), 64'({1'b1, 1'b0, mem_rd(32'h104)}));
    if_req = 0;
    tick;

    // Fairness: D D D D F D with both requests held.
    chk("stored_word", 64'(mem_rd(32'h200)), 64'h12345678);
    d_req = 1; d_we = 0; d_addr = 32'h500; if_req = 1; if_addr = 32'h400;
    for (int k = 0; k < 6; k++) begin
      t = 0;
      while (!m_req && t < 20) begin tick; t++; end
      chk($sformatf("fair_grant%0d", k), 64'(m_addr), (k == 4) ? 64'h400 : 64'h500);
      serve(0, 0);
      chk($sformatf("fair_done%0d", k), 64'({if_done, d_done}), (k == 4) ? 64'h2 : 64'h1);
      if (k == 4) if_req = 0;
    end
    d_req = 0;
    tick;

    // Delayed gnt: fields hold for 5 cycles, done one cycle after rvalid.
    d_req = 1; d_we = 1; d_addr = 32'h600; d_wdata = 32'hCAFE0001; d_wstrb = 4'b0101;
    tick; tick;
    chk("delay_issue", 64'({m_req, m_addr}), 64'({1'b1, 32'h600}));
    serve(5, 1);
    chk("delay_done", 64'(d_done), 64'h1);
    d_req = 0;
    tick;

    // Same-cycle gnt+rvalid load.
    d_req = 1; d_we = 0; d_addr = 32'h300;                       // cycle 0
    tick;                                                        // cycle 1
    m_gnt = 1; m_rvalid = 1; m_rdata = 32'hA5A5A5A5;
    tick;                                                        // cycle 2
    m_gnt = 0; m_rvalid = 0;
    chk("fast_load_done", 64'({d_done, d_rdata}), 64'({1'b1, 32'hA5A5A5A5}));
    d_req = 0;
    tick;
    chk("fast_load_idle", 64'({d_done, busy}), 64'h0);

    // Reset in WAIT, then a stale rvalid.
    d_req = 1; d_we = 0; d_addr = 32'h700;
    tick;
    m_gnt = 1;
    tick;
    m_gnt = 0;
    chk("rst_in_wait_busy", 64'({busy, m_req}), 64'h2);
    reset = 1; d_req = 0;
    tick;
    reset = 0; m_rvalid = 1; m_rdata = 32'h13579BDF;
    tick;
    m_rvalid = 0;
    chk_idle_zero("rst_mid");
    tick;
    chk("rst_stale_rvalid", 64'({if_done, d_done, busy}), 64'h0);

    // Random traffic.
    fork
      rand_fetch(40);
      rand_data(60);
      mem_loop();
    join
    repeat (4) tick;
    chk("sb_drain", 64'(sb.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
